// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and shared widths for the PLL lock sequencer.
package pll_seq_pkg;
  localparam int RETRY_W = 8;
  typedef enum logic [2:0] {PULSE, WAIT_LOCK, STABLE, RELEASE, RUN} state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for one asynchronous status level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk) begin
    if (rst) {r_q, r_meta} <= 2'b00;
    else {r_q, r_meta} <= {r_meta, i_d};
  end
  assign o_q = r_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL reset, qualifies lock, then releases domain resets in ascending order.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 4,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int STAGGER_CYCLES      = 8,
  parameter int CNT_W               = 20
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  input  logic                   force_relock,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   lock_timeout,
  output logic [RETRY_W-1:0]     retry_count
);
  localparam int IDX_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TMO   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STB   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STG   = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_DOMAINS - 1);
  state_t                 r_state, w_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic [IDX_W-1:0]       r_idx, w_idx;
  logic [NUM_DOMAINS-1:0] r_dom, w_dom;
  logic                   r_pll_rst, r_ready, r_timeout;
  logic [RETRY_W-1:0]     r_retry;
  logic                   w_lk, w_zero, w_lost, w_force, w_tmo;

  sync2 u_lock_sync (.clk(refclk), .rst(rst), .i_d(locked), .o_q(w_lk));

  assign w_zero  = r_cnt == '0;
  assign w_lost  = !w_lk && (r_state == RELEASE || r_state == RUN);
  assign w_force = force_relock && r_state != PULSE;
  // A lock arriving on the last wait cycle beats the timeout; a relock request beats both.
  assign w_tmo   = r_state == WAIT_LOCK && !w_lk && w_zero && !w_force;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= PULSE;
      r_cnt   <= C_PULSE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
    end
  end

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt - CNT_W'(1);
    w_idx  = r_idx;
    if (w_lost || w_force || w_tmo) begin
      w_next = PULSE;
      w_cnt  = C_PULSE;
    end else begin
      case (r_state)
        PULSE:     if (w_zero) begin w_next = WAIT_LOCK; w_cnt = C_TMO; end
        WAIT_LOCK: if (w_lk) begin w_next = STABLE; w_cnt = C_STB; end
        STABLE:
          if (!w_lk) begin
            w_next = WAIT_LOCK;
            w_cnt  = C_TMO;
          end else if (w_zero) begin
            w_next = RELEASE;
            w_cnt  = '0;
            w_idx  = '0;
          end
        RELEASE:
          if (w_zero) begin
            w_next = r_idx == LAST ? RUN : RELEASE;
            w_cnt  = C_STG;
            w_idx  = r_idx + IDX_W'(1);
          end
        default: w_cnt = r_cnt;
      endcase
    end
  end

  always_comb begin
    w_dom = r_dom;
    if (w_next == PULSE) w_dom = '1;
    else if (r_state == RELEASE && w_zero) w_dom[r_idx] = 1'b0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pll_rst <= 1'b1;
      r_dom     <= '1;
      r_ready   <= 1'b0;
      r_timeout <= 1'b0;
      r_retry   <= '0;
    end else begin
      r_pll_rst <= w_next == PULSE;
      r_dom     <= w_dom;
      r_ready   <= w_next == RUN;
      r_timeout <= r_timeout | w_tmo;
      r_retry   <= ((w_lost || w_tmo) && r_retry != '1) ? r_retry + RETRY_W'(1) : r_retry;
    end
  end

  assign pll_rst      = r_pll_rst;
  assign domain_rst   = r_dom;
  assign ready        = r_ready;
  assign lock_timeout = r_timeout;
  assign retry_count  = r_retry;
endmodule
